audio_adc_rx: RTL and testbench

AUDIO_ADC_RX -- requirements
Module: audio_adc_rx

---
 rtl/audio_pkg.sv | 13 +
 rtl/sync_rise_det.sv | 29 ++
 rtl/audio_adc_rx.sv | 144 ++++++++++++++
 tb/tb_audio_adc_rx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants and FSM state encoding for the serial audio ADC receiver.
package audio_pkg;
   localparam int DATA_W    = 16;
   localparam int FRAME_LEN = 2 * DATA_W;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SYNC    = 3'd1,
      SHIFT_L = 3'd2,
      SHIFT_R = 3'd3,
      DONE    = 3'd4
   } state_e;
endpackage

// File: rtl/sync_rise_det.sv
// Multi-bit synchronizer chain with rising-edge strobe on bit 0 (the bit clock).
module sync_rise_det #(
   parameter int STAGES = 2,
   parameter int WIDTH  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o,
   output logic             rise_o
);
   logic [STAGES-1:0][WIDTH-1:0] sync_q;
   logic                         prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q[0] <= async_i;
         for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= sync_q[STAGES-1][0];
      end
   end

   // Edge flop resets low, so a line already high at reset release yields one strobe.
   assign sync_o = sync_q[STAGES-1];
   assign rise_o = sync_q[STAGES-1][0] & ~prev_q;
endmodule

// File: rtl/audio_adc_rx.sv
// DSP-mode-A serial audio receiver: oversamples BCLK, deserializes a left/right
// word pair per frame and holds it in a valid/ready output register.
module audio_adc_rx
   import audio_pkg::*;
#(
   parameter int DATA_W      = audio_pkg::DATA_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              BCLK,
   input  logic              ADC_LR_CLK,
   input  logic              ADC_DATA,
   output logic [DATA_W-1:0] left_sample,
   output logic [DATA_W-1:0] right_sample,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              overrun,
   output logic              frame_error
);
   localparam logic [4:0] LAST_BIT = 5'(DATA_W - 1);

   logic [2:0] sync_vec;
   logic       bclk_rise;
   logic       lr_s;
   logic       data_s;

   sync_rise_det #(
      .STAGES (SYNC_STAGES),
      .WIDTH  (3)
   ) u_sync (
      .clk     (clk),
      .reset   (reset),
      .async_i ({ADC_DATA, ADC_LR_CLK, BCLK}),
      .sync_o  (sync_vec),
      .rise_o  (bclk_rise)
   );

   assign lr_s   = sync_vec[1];
   assign data_s = sync_vec[2];

   state_e            state_q, state_d;
   logic [4:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] left_sr_q, left_sr_d;
   logic [DATA_W-1:0] right_sr_q, right_sr_d;
   logic [DATA_W-1:0] left_q, left_d;
   logic [DATA_W-1:0] right_q, right_d;
   logic              valid_q, valid_d;
   logic              ovr_q, ovr_d;
   logic              ferr_q, ferr_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         left_sr_q  <= '0;
         right_sr_q <= '0;
         left_q     <= '0;
         right_q    <= '0;
         valid_q    <= 1'b0;
         ovr_q      <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         left_sr_q  <= left_sr_d;
         right_sr_q <= right_sr_d;
         left_q     <= left_d;
         right_q    <= right_d;
         valid_q    <= valid_d;
         ovr_q      <= ovr_d;
         ferr_q     <= ferr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      left_sr_d  = left_sr_q;
      right_sr_d = right_sr_q;
      left_d     = left_q;
      right_d    = right_q;
      ovr_d      = ovr_q;
      ferr_d     = 1'b0;
      valid_d    = valid_q && !sample_ready;

      case (state_q)
         IDLE: begin
            if (bclk_rise && lr_s && enable) state_d = SYNC;
         end
         SYNC: begin
            if (!enable) begin
               state_d   = IDLE;
               bit_cnt_d = '0;
            end else if (bclk_rise) begin
               // One-bit delay after frame sync: this strobe carries the left MSB.
               left_sr_d = {left_sr_q[DATA_W-2:0], data_s};
               bit_cnt_d = 5'd1;
               state_d   = SHIFT_L;
            end
         end
         SHIFT_L, SHIFT_R: begin
            if (!enable) begin
               state_d   = IDLE;
               bit_cnt_d = '0;
            end else if (bclk_rise) begin
               if (lr_s) begin
                  ferr_d    = 1'b1;
                  bit_cnt_d = '0;
                  state_d   = SYNC;
               end else begin
                  if (state_q == SHIFT_L) left_sr_d  = {left_sr_q[DATA_W-2:0], data_s};
                  else                    right_sr_d = {right_sr_q[DATA_W-2:0], data_s};
                  if (bit_cnt_q == LAST_BIT) begin
                     bit_cnt_d = '0;
                     state_d   = (state_q == SHIFT_L) ? SHIFT_R : DONE;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 5'd1;
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            // A load in the same cycle as a handshake keeps valid high.
            if (!valid_q || sample_ready) begin
               left_d  = left_sr_q;
               right_d = right_sr_q;
               valid_d = 1'b1;
            end else begin
               ovr_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign left_sample  = left_q;
   assign right_sample = right_q;
   assign sample_valid = valid_q;
   assign overrun      = ovr_q;
   assign frame_error  = ferr_q;
endmodule

// File: tb/tb_audio_adc_rx.sv
// Directed bench for audio_adc_rx with a pair scoreboard drained on every handshake.
module tb_audio_adc_rx;
   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        BCLK = 1'b0;
   logic        ADC_LR_CLK;
   logic        ADC_DATA;
   logic [15:0] left_sample;
   logic [15:0] right_sample;
   logic        sample_valid;
   logic        sample_ready;
   logic        overrun;
   logic        frame_error;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          ferr_cnt = 0;
   logic [31:0] exp_q[$];

   audio_adc_rx dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .BCLK         (BCLK),
      .ADC_LR_CLK   (ADC_LR_CLK),
      .ADC_DATA     (ADC_DATA),
      .left_sample  (left_sample),
      .right_sample (right_sample),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overrun      (overrun),
      .frame_error  (frame_error)
   );

   // 50 MHz clk; BCLK = clk/16, offset so its edges sit 5 ns before a clk rise.
   initial forever #10 clk = ~clk;
   initial begin
      #5;
      forever #160 BCLK = ~BCLK;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (frame_error === 1'b1) ferr_cnt++;
      if (reset === 1'b0 && sample_valid === 1'b1 && sample_ready === 1'b1) begin
         chk("unexpected_valid", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) chk("pair", {left_sample, right_sample}, exp_q.pop_front());
      end
   end

   task automatic send_bit(input logic lr, input logic d);
      @(negedge BCLK);
      ADC_LR_CLK = lr;
      ADC_DATA   = d;
   endtask

   task automatic send_word(input logic [15:0] w, input int nbits);
      for (int i = 15; i > 15 - nbits; i--) send_bit(1'b0, w[i]);
   endtask

   // Returns on the BCLK rise that captures the right LSB.
   task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
      send_bit(1'b1, 1'b0);
      send_word(l, 16);
      send_word(r, 16);
      @(posedge BCLK);
   endtask

   task automatic wait_empty();
      for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(posedge clk);
      @(negedge clk);
      chk("drain", 32'(exp_q.size()), 32'd0);
   endtask

   int f0;

   initial begin
      reset = 1'b1; enable = 1'b1; sample_ready = 1'b1;
      ADC_LR_CLK = 1'b0; ADC_DATA = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_left",  32'(left_sample),  32'd0);
      chk("rst_right", 32'(right_sample), 32'd0);
      chk("rst_valid", 32'(sample_valid), 32'd0);
      chk("rst_ovr",   32'(overrun),      32'd0);
      chk("rst_ferr",  32'(frame_error),  32'd0);
      reset = 1'b0;

      // Basic frame, ready high; valid rises two clk after the right-LSB strobe.
      exp_q.push_back({16'hA5C3, 16'h0F0F});
      send_frame(16'hA5C3, 16'h0F0F);
      #55 chk("A_valid_early", 32'(sample_valid), 32'd0);
      #20 chk("A_valid", 32'(sample_valid), 32'd1);
      chk("A_left",  32'(left_sample),  32'h0000A5C3);
      chk("A_right", 32'(right_sample), 32'h00000F0F);
      wait_empty();
      chk("A_ovr", 32'(overrun), 32'd0);

      // Two frames without a consumer: first pair held, overrun set.
      sample_ready = 1'b0;
      exp_q.push_back({16'hA5C3, 16'h0F0F});
      send_frame(16'hA5C3, 16'h0F0F);
      send_frame(16'h1111, 16'h2222);
      #75;
      chk("B_ovr",   32'(overrun),      32'd1);
      chk("B_valid", 32'(sample_valid), 32'd1);
      chk("B_left",  32'(left_sample),  32'h0000A5C3);
      chk("B_right", 32'(right_sample), 32'h00000F0F);
      sample_ready = 1'b1;
      wait_empty();

      // Frame sync after 7 left bits restarts the frame.
      f0 = ferr_cnt;
      send_bit(1'b1, 1'b0);
      send_word(16'hFFFF, 7);
      exp_q.push_back({16'h1234, 16'h8001});
      send_frame(16'h1234, 16'h8001);
      wait_empty();
      chk("C_ferr_pulses", 32'(ferr_cnt - f0), 32'd1);

      // Enable dropped during the right word.
      send_bit(1'b1, 1'b0);
      send_word(16'hFFFF, 16);
      send_word(16'hFFFF, 5);
      @(posedge BCLK);
      #100 enable = 1'b0;
      ADC_LR_CLK = 1'b0;
      #400;
      chk("D_valid", 32'(sample_valid), 32'd0);
      enable = 1'b1;
      exp_q.push_back({16'hBEEF, 16'h0123});
      send_frame(16'hBEEF, 16'h0123);
      wait_empty();

      // Reset in the middle of the left word.
      send_bit(1'b1, 1'b0);
      send_word(16'hC3C3, 8);
      @(posedge BCLK);
      #100 reset = 1'b1;
      @(posedge clk);
      #1;
      chk("E_left",  32'(left_sample),  32'd0);
      chk("E_right", 32'(right_sample), 32'd0);
      chk("E_valid", 32'(sample_valid), 32'd0);
      chk("E_ovr",   32'(overrun),      32'd0);
      chk("E_ferr",  32'(frame_error),  32'd0);
      reset = 1'b0;
      for (int i = 7; i >= 0; i--) send_bit(1'b0, i[0]);
      send_word(16'h5A5A, 16);
      @(posedge BCLK);
      #100 chk("E_no_valid", 32'(sample_valid), 32'd0);

      // DONE load in the same cycle as a handshake.
      sample_ready = 1'b0;
      exp_q.push_back({16'h1357, 16'h2468});
      send_frame(16'h1357, 16'h2468);
      #75 chk("F_valid1", 32'(sample_valid), 32'd1);
      exp_q.push_back({16'h9ABC, 16'hDEF0});
      send_frame(16'h9ABC, 16'hDEF0);
      #50 sample_ready = 1'b1;
      #20 sample_ready = 1'b0;
      #5;
      chk("F_valid", 32'(sample_valid), 32'd1);
      chk("F_left",  32'(left_sample),  32'h00009ABC);
      chk("F_right", 32'(right_sample), 32'h0000DEF0);
      chk("F_ovr",   32'(overrun),      32'd0);
      chk("F_pending", 32'(exp_q.size()), 32'd1);
      sample_ready = 1'b1;
      wait_empty();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
